sample_dma_requester: RTL and testbench



---
 rtl/sampler_dma_pkg.sv | 24 ++
 rtl/sample_dma_requester.sv | 176 +++++++++++++++++
 tb/tb_sample_dma_requester.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sampler_dma_pkg.sv
// Shared definitions for the sampler DMA unit.
//   state_t          - requester FSM states
//   DMA_BURST_BEATS  - 32-bit beats per DMA read command
//   DMA_BURST_BYTES  - bytes per DMA read command
//   DESC_*_BIT       - control-bit positions inside a sample descriptor word
package sampler_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SAMPLE,
    ISSUE,
    WAIT_DONE,
    NEXT,
    LOOP_WAIT
  } state_t;

  localparam int unsigned DMA_BURST_BEATS = 64;
  localparam int unsigned DMA_BURST_BYTES = DMA_BURST_BEATS * 4;

  localparam int unsigned DESC_VALID_BIT    = 0;
  localparam int unsigned DESC_LAST_BIT     = 1;
  localparam int unsigned DESC_OVERFLOW_BIT = 7;

endpackage

// File: rtl/sample_dma_requester.sv
// Consumer side of the sample-info fetcher: issues one fixed-size DMA read per
// valid, non-overflowed sample, advances the fetcher, and runs one pass over
// the sample list per audio frame tick.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   start, stop           - begin (level, sampled in IDLE) / abort operation
//   frame_tick            - one-cycle pulse per audio frame
//   sample_*              - current descriptor from the fetcher
//   load_next_sample      - one-cycle advance request to the fetcher
//   all_samples_invalid   - pulse when no valid sample appears for INVALID_TIMEOUT cycles
//   dma_cmd_*             - read command channel (valid/ready) and completion pulse
//   loop_done             - pulse when the last slot of a pass is retired
//   loop_cmd_count        - commands issued in the last completed pass
//   frame_overrun         - sticky: a frame tick arrived while one was already pending
module sample_dma_requester #(
  parameter int unsigned SAMPLE_ID_WIDTH = 6,
  parameter int unsigned DMA_ADDR_WIDTH  = 32,
  parameter int unsigned DMA_BURST_BEATS = sampler_dma_pkg::DMA_BURST_BEATS,
  parameter int unsigned INVALID_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       frame_tick,
  input  logic [DMA_ADDR_WIDTH-1:0]  sample_addr,
  input  logic [SAMPLE_ID_WIDTH-1:0] sample_id,
  input  logic                       sample_valid,
  input  logic                       sample_overflow,
  input  logic                       sample_last,
  output logic                       load_next_sample,
  output logic                       all_samples_invalid,
  output logic                       dma_cmd_valid,
  input  logic                       dma_cmd_ready,
  output logic [DMA_ADDR_WIDTH-1:0]  dma_cmd_addr,
  output logic [SAMPLE_ID_WIDTH-1:0] dma_cmd_id,
  output logic [7:0]                 dma_cmd_len,
  input  logic                       dma_cmd_done,
  output logic                       loop_done,
  output logic [SAMPLE_ID_WIDTH:0]   loop_cmd_count,
  output logic                       frame_overrun
);
  import sampler_dma_pkg::*;

  localparam int unsigned TO_W = (INVALID_TIMEOUT > 1) ? $clog2(INVALID_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(INVALID_TIMEOUT - 1);

  state_t                     state_q, state_d;
  logic [DMA_ADDR_WIDTH-1:0]  addr_q;
  logic [SAMPLE_ID_WIDTH-1:0] id_q;
  logic                       last_q;
  logic                       stop_seen_q;
  logic                       pending_q;
  logic [SAMPLE_ID_WIDTH:0]   cmd_cnt_q;
  logic [TO_W-1:0]            to_cnt_q;
  logic                       stop_eff;
  logic                       start_go;

  // stop may be a short pulse; remember it until the FSM gets back to IDLE
  assign stop_eff     = stop | stop_seen_q;
  assign start_go     = start & ~stop;
  assign dma_cmd_addr = addr_q;
  assign dma_cmd_id   = id_q;
  assign dma_cmd_len  = 8'(DMA_BURST_BEATS - 1);

  always_comb begin
    state_d             = state_q;
    load_next_sample    = 1'b0;
    all_samples_invalid = 1'b0;
    dma_cmd_valid       = 1'b0;
    loop_done           = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_go) state_d = WAIT_SAMPLE;
      end
      WAIT_SAMPLE: begin
        if (stop_eff) begin
          state_d = IDLE;
        end else if (sample_valid) begin
          state_d = sample_overflow ? NEXT : ISSUE;
        end else if (to_cnt_q == TO_LAST) begin
          all_samples_invalid = 1'b1;
          state_d             = IDLE;
        end
      end
      ISSUE: begin
        dma_cmd_valid = 1'b1;
        if (dma_cmd_ready) state_d = stop_eff ? IDLE : WAIT_DONE;
      end
      WAIT_DONE: begin
        if (dma_cmd_done) state_d = stop_eff ? IDLE : NEXT;
      end
      NEXT: begin
        if (stop_eff) begin
          state_d = IDLE;
        end else begin
          load_next_sample = 1'b1;
          if (last_q) begin
            loop_done = 1'b1;
            state_d   = LOOP_WAIT;
          end else begin
            state_d = WAIT_SAMPLE;
          end
        end
      end
      LOOP_WAIT: begin
        if (stop_eff)                     state_d = IDLE;
        else if (frame_tick || pending_q) state_d = WAIT_SAMPLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      id_q           <= '0;
      last_q         <= 1'b0;
      stop_seen_q    <= 1'b0;
      pending_q      <= 1'b0;
      frame_overrun  <= 1'b0;
      cmd_cnt_q      <= '0;
      loop_cmd_count <= '0;
      to_cnt_q       <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE) stop_seen_q <= 1'b0;
      else if (stop)       stop_seen_q <= 1'b1;

      // Staying in WAIT_SAMPLE implies sample_valid was low this cycle
      if (state_q == WAIT_SAMPLE && state_d == WAIT_SAMPLE) to_cnt_q <= to_cnt_q + 1'b1;
      else                                                  to_cnt_q <= '0;

      case (state_q)
        IDLE: begin
          if (start_go) cmd_cnt_q <= '0;
        end
        WAIT_SAMPLE: begin
          if (!stop_eff && sample_valid) begin
            last_q <= sample_last;
            if (!sample_overflow) begin
              addr_q <= sample_addr;
              id_q   <= sample_id;
            end
          end
        end
        ISSUE: begin
          if (dma_cmd_ready && cmd_cnt_q != '1) cmd_cnt_q <= cmd_cnt_q + 1'b1;
        end
        NEXT: begin
          if (loop_done) begin
            loop_cmd_count <= cmd_cnt_q;
            cmd_cnt_q      <= '0;
          end
        end
        default: ;
      endcase

      // A tick in NEXT (the cycle LOOP_WAIT is entered) lands here as pending
      if (state_q == IDLE) begin
        if (start_go) begin
          pending_q     <= 1'b0;
          frame_overrun <= 1'b0;
        end
      end else if (state_q == LOOP_WAIT) begin
        if (state_d == WAIT_SAMPLE) pending_q <= 1'b0;
      end else if (frame_tick) begin
        if (pending_q) frame_overrun <= 1'b1;
        else           pending_q     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_dma_requester.sv
module tb_sample_dma_requester;
  localparam int unsigned IDW = 6;
  localparam int unsigned AW  = 32;

  logic           clk = 1'b0;
  logic           reset_n, start, stop, frame_tick;
  logic [AW-1:0]  sample_addr;
  logic [IDW-1:0] sample_id;
  logic           sample_valid, sample_overflow, sample_last;
  logic           load_next_sample, all_samples_invalid;
  logic           dma_cmd_valid, dma_cmd_ready, dma_cmd_done;
  logic [AW-1:0]  dma_cmd_addr;
  logic [IDW-1:0] dma_cmd_id;
  logic [7:0]     dma_cmd_len;
  logic           loop_done;
  logic [IDW:0]   loop_cmd_count;
  logic           frame_overrun;

  always #5 clk = ~clk;

  sample_dma_requester #(
    .SAMPLE_ID_WIDTH(IDW),
    .DMA_ADDR_WIDTH (AW),
    .DMA_BURST_BEATS(64),
    .INVALID_TIMEOUT(64)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .start              (start),
    .stop               (stop),
    .frame_tick         (frame_tick),
    .sample_addr        (sample_addr),
    .sample_id          (sample_id),
    .sample_valid       (sample_valid),
    .sample_overflow    (sample_overflow),
    .sample_last        (sample_last),
    .load_next_sample   (load_next_sample),
    .all_samples_invalid(all_samples_invalid),
    .dma_cmd_valid      (dma_cmd_valid),
    .dma_cmd_ready      (dma_cmd_ready),
    .dma_cmd_addr       (dma_cmd_addr),
    .dma_cmd_id         (dma_cmd_id),
    .dma_cmd_len        (dma_cmd_len),
    .dma_cmd_done       (dma_cmd_done),
    .loop_done          (loop_done),
    .loop_cmd_count     (loop_cmd_count),
    .frame_overrun      (frame_overrun)
  );

  typedef struct { logic [AW-1:0] addr; logic [IDW-1:0] id; bit ovf; bit last; } slot_t;
  typedef struct { logic [AW-1:0] addr; logic [IDW-1:0] id; } cmd_t;

  slot_t slots[4];
  cmd_t  exp_cmd[$];
  int    exp_loop[$];
  int    n_pass = 0, n_total = 0;
  int    n_load = 0, n_loop = 0, n_hs = 0, n_inval = 0;
  int    cyc = 0, inval_cyc = 0;
  bit    fetch_en = 1'b0;
  int    ptr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Fetcher model: presents slots[ptr] two cycles after each advance
  initial begin
    int gap;
    gap = 2;
    sample_valid = 1'b0; sample_addr = '0; sample_id = '0;
    sample_overflow = 1'b0; sample_last = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!fetch_en) begin
        sample_valid = 1'b0; gap = 2;
      end else if (load_next_sample) begin
        sample_valid = 1'b0;
        ptr = slots[ptr].last ? 0 : ptr + 1;
        gap = 2;
      end else if (gap > 0) begin
        gap--;
      end else begin
        sample_addr     = slots[ptr].addr;
        sample_id       = slots[ptr].id;
        sample_overflow = slots[ptr].ovf;
        sample_last     = slots[ptr].last;
        sample_valid    = 1'b1;
      end
    end
  end

  // DMA responder: completion pulse 5 cycles after each handshake
  initial begin
    int cnt;
    cnt = 0;
    dma_cmd_done = 1'b0;
    forever begin
      @(negedge clk); #1;
      dma_cmd_done = 1'b0;
      if (!reset_n) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) dma_cmd_done = 1'b1;
        end
        if (dma_cmd_valid && dma_cmd_ready) cnt = 5;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    bit   loop_chk;
    int   loop_exp;
    cmd_t e;
    loop_chk = 1'b0;
    loop_exp = 0;
    forever begin
      @(negedge clk); #2;
      if (loop_chk) begin
        check("loop_cmd_count", int'(loop_cmd_count), loop_exp);
        loop_chk = 1'b0;
      end
      if (dma_cmd_valid) begin
        if (exp_cmd.size() == 0) begin
          fail("unexpected_cmd");
        end else begin
          e = exp_cmd[0];
          check("cmd_addr", int'(dma_cmd_addr), int'(e.addr));
          check("cmd_id", int'(dma_cmd_id), int'(e.id));
          if (dma_cmd_ready) begin
            check("cmd_len", int'(dma_cmd_len), 63);
            void'(exp_cmd.pop_front());
            n_hs++;
          end
        end
      end
      if (load_next_sample) n_load++;
      if (loop_done) begin
        n_loop++;
        if (exp_loop.size() == 0) fail("unexpected_loop_done");
        else begin
          loop_exp = exp_loop.pop_front();
          loop_chk = 1'b1;
        end
      end
      if (all_samples_invalid) begin
        n_inval++;
        inval_cyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic prep_slots(input bit ovf1);
    fetch_en = 1'b0;
    @(negedge clk);
    slots[0] = '{addr: 32'h1000, id: 6'd0, ovf: 1'b0, last: 1'b0};
    slots[1] = '{addr: 32'h2000, id: 6'd1, ovf: ovf1, last: 1'b0};
    slots[2] = '{addr: 32'h3000, id: 6'd2, ovf: 1'b0, last: 1'b1};
    slots[3] = '{addr: 32'h0, id: 6'd3, ovf: 1'b0, last: 1'b1};
    ptr = 0;
    fetch_en = 1'b1;
  endtask

  task automatic push_loop(input bit ovf1);
    exp_cmd.push_back('{addr: 32'h1000, id: 6'd0});
    if (!ovf1) exp_cmd.push_back('{addr: 32'h2000, id: 6'd1});
    exp_cmd.push_back('{addr: 32'h3000, id: 6'd2});
    exp_loop.push_back(ovf1 ? 2 : 3);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_loops(input int target, input int budget, input string name);
    int i;
    i = 0;
    while (n_loop < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (n_loop < target) fail(name);
  endtask

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  initial begin
    int bl, bp, bh, bi, t0, i;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; frame_tick = 1'b0; dma_cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    check("rst_cmd_valid", int'(dma_cmd_valid), 0);
    check("rst_load_next", int'(load_next_sample), 0);
    check("rst_invalid", int'(all_samples_invalid), 0);
    check("rst_loop_done", int'(loop_done), 0);
    check("rst_loop_cnt", int'(loop_cmd_count), 0);
    check("rst_overrun", int'(frame_overrun), 0);
    check("rst_addr", int'(dma_cmd_addr), 0);
    check("rst_len", int'(dma_cmd_len), 63);
    @(negedge clk); reset_n = 1'b1;

    // Three valid slots, one pass
    prep_slots(1'b0); push_loop(1'b0);
    bl = n_load; bp = n_loop; bh = n_hs;
    pulse_start();
    wait_loops(bp + 1, 300, "t1_loop_timeout");
    repeat (3) @(negedge clk);
    check("t1_loads", n_load - bl, 3);
    check("t1_cmds", n_hs - bh, 3);
    check("t1_loops", n_loop - bp, 1);
    pulse_stop();

    // Slot 1 overflowed: skipped but still advanced
    prep_slots(1'b1); push_loop(1'b1);
    bl = n_load; bp = n_loop; bh = n_hs;
    pulse_start();
    wait_loops(bp + 1, 300, "t2_loop_timeout");
    repeat (3) @(negedge clk);
    check("t2_loads", n_load - bl, 3);
    check("t2_cmds", n_hs - bh, 2);
    pulse_stop();

    // No valid sample: timeout pulse on WAIT_SAMPLE cycle 64, then IDLE
    fetch_en = 1'b0;
    repeat (2) @(negedge clk);
    bi = n_inval; bh = n_hs;
    t0 = cyc; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (100) @(negedge clk);
    check("t3_pulses", n_inval - bi, 1);
    check("t3_pulse_cycle", inval_cyc - t0, 64);
    prep_slots(1'b0);
    repeat (20) @(negedge clk);
    check("t3_idle_no_cmd", n_hs - bh, 0);
    check("t3_idle_valid", int'(dma_cmd_valid), 0);

    // Ready held low, stop during ISSUE
    fetch_en = 1'b0;
    @(negedge clk);
    slots[0] = '{addr: 32'h4000, id: 6'd5, ovf: 1'b0, last: 1'b1};
    ptr = 0; dma_cmd_ready = 1'b0; fetch_en = 1'b1;
    exp_cmd.push_back('{addr: 32'h4000, id: 6'd5});
    bl = n_load; bp = n_loop; bh = n_hs;
    pulse_start();
    i = 0;
    while (dma_cmd_valid !== 1'b1 && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (dma_cmd_valid !== 1'b1) fail("t4_valid_timeout");
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    repeat (8) @(negedge clk);
    dma_cmd_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_handshakes", n_hs - bh, 1);
    repeat (20) @(negedge clk);
    check("t4_no_load", n_load - bl, 0);
    check("t4_no_loop", n_loop - bp, 0);
    check("t4_idle_valid", int'(dma_cmd_valid), 0);

    // Two ticks within one pass: overrun, then immediate second pass
    prep_slots(1'b0); push_loop(1'b0); push_loop(1'b0);
    bp = n_loop;
    pulse_start();
    repeat (3) @(negedge clk);
    tick();
    repeat (4) @(negedge clk);
    tick();
    wait_loops(bp + 2, 400, "t5_loop_timeout");
    repeat (3) @(negedge clk);
    check("t5_overrun", int'(frame_overrun), 1);
    check("t5_loops", n_loop - bp, 2);
    pulse_stop();
    check("t5_overrun_sticky", int'(frame_overrun), 1);
    fetch_en = 1'b0;
    @(negedge clk);
    pulse_start();
    check("t5_overrun_cleared", int'(frame_overrun), 0);
    pulse_stop();

    // Asynchronous reset while waiting for completion
    prep_slots(1'b0); push_loop(1'b0);
    exp_loop.delete();
    bh = n_hs;
    pulse_start();
    i = 0;
    while (n_hs == bh && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (n_hs == bh) fail("t6_hs_timeout");
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(dma_cmd_valid), 0);
    check("t6_rst_load", int'(load_next_sample), 0);
    check("t6_rst_addr", int'(dma_cmd_addr), 0);
    check("t6_rst_loop_cnt", int'(loop_cmd_count), 0);
    check("t6_rst_overrun", int'(frame_overrun), 0);
    exp_cmd.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    push_loop(1'b0);
    bl = n_load; bp = n_loop;
    pulse_start();
    wait_loops(bp + 1, 300, "t6_loop_timeout");
    repeat (3) @(negedge clk);
    check("t6_loads", n_load - bl, 3);
    pulse_stop();

    check("cmd_queue_drained", exp_cmd.size(), 0);
    check("loop_queue_drained", exp_loop.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
